cameralink_uart_core: RTL and testbench

CAMERALINK_UART_CORE -- requirements
Module: cameralink_uart_core

---
 rtl/cameralink_uart_core.sv | 242 ++++++++++++++++++++++++
 tb/tb_cameralink_uart_core.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cameralink_uart_core.sv
// 8N1 UART for a CameraLink serial channel: a registered transmitter and a
// synchronized, mid-bit-sampling receiver that run independently on one clock.
module cameralink_uart_core #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       s_axi_aclk,
    input  logic       s_axi_areset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_drop,
    output logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_frame_error,
    output logic       uart_tx,
    input  logic       uart_rx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t         tx_state, tx_state_next;
    logic [CW-1:0]     tx_cnt, tx_cnt_next;
    logic [2:0]        tx_bit, tx_bit_next;
    logic [7:0]        tx_shift, tx_shift_next;
    logic              tx_line_next;
    logic              tx_busy_next;
    logic              tx_drop_next;

    // NOTE: sequential state is written only with <=, so every register in the
    // design sees the pre-edge value of every other register.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_drop  <= 1'b0;
        end else begin
            tx_state <= tx_state_next;
            tx_cnt   <= tx_cnt_next;
            tx_bit   <= tx_bit_next;
            tx_shift <= tx_shift_next;
            uart_tx  <= tx_line_next;
            tx_busy  <= tx_busy_next;
            tx_drop  <= tx_drop_next;
        end
    end

    // NOTE: every signal gets a default before the case, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_next   = tx_cnt;
        tx_bit_next   = tx_bit;
        tx_shift_next = tx_shift;
        tx_line_next  = uart_tx;
        tx_drop_next  = tx_start && (tx_state != TX_IDLE);

        unique case (tx_state)
            TX_IDLE: begin
                tx_cnt_next  = '0;
                tx_bit_next  = '0;
                tx_line_next = 1'b1;
                if (tx_start) begin
                    tx_shift_next = tx_data;
                    tx_state_next = TX_START;
                    tx_line_next  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_state_next = TX_DATA;
                    tx_line_next  = tx_shift[0];
                end else begin
                    tx_cnt_next = tx_cnt + CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_next = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_next = TX_STOP;
                        tx_line_next  = 1'b1;
                    end else begin
                        // Shift right so the next data bit is always at [0].
                        tx_bit_next   = tx_bit + 3'd1;
                        tx_shift_next = {1'b0, tx_shift[7:1]};
                        tx_line_next  = tx_shift[1];
                    end
                end else begin
                    tx_cnt_next = tx_cnt + CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_state_next = TX_IDLE;
                end else begin
                    tx_cnt_next = tx_cnt + CNT_ONE;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase

        tx_busy_next = (tx_state_next != TX_IDLE);
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [1:0]    rx_sync;
    logic          rx_line;
    rx_state_t     rx_state, rx_state_next;
    logic [CW-1:0] rx_cnt, rx_cnt_next;
    logic [2:0]    rx_bit, rx_bit_next;
    logic [7:0]    rx_shift, rx_shift_next;
    logic [7:0]    rx_data_next;
    logic          rx_ready_next;
    logic          rx_error_next;

    // Synchronizer resets to the idle-high line level so reset never looks
    // like a start bit.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            rx_sync <= 2'b11;
        end else begin
            rx_sync <= {rx_sync[0], uart_rx};
        end
    end

    assign rx_line = rx_sync[1];

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            rx_state       <= RX_IDLE;
            rx_cnt         <= '0;
            rx_bit         <= '0;
            rx_shift       <= '0;
            rx_data        <= '0;
            rx_ready       <= 1'b0;
            rx_frame_error <= 1'b0;
        end else begin
            rx_state       <= rx_state_next;
            rx_cnt         <= rx_cnt_next;
            rx_bit         <= rx_bit_next;
            rx_shift       <= rx_shift_next;
            rx_data        <= rx_data_next;
            rx_ready       <= rx_ready_next;
            rx_frame_error <= rx_error_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_next   = rx_cnt;
        rx_bit_next   = rx_bit;
        rx_shift_next = rx_shift;
        rx_data_next  = rx_data;
        rx_ready_next = 1'b0;
        rx_error_next = 1'b0;

        unique case (rx_state)
            RX_IDLE: begin
                rx_cnt_next = '0;
                rx_bit_next = '0;
                if (!rx_line) begin
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                // Half a bit in: still low means a real start bit, and this
                // instant becomes the sampling phase for the rest of the frame.
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_next   = '0;
                    rx_state_next = rx_line ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_next = rx_cnt + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rx_line, rx_shift[7:1]};
                    if (rx_bit == 3'd7) begin
                        rx_state_next = RX_STOP;
                    end else begin
                        rx_bit_next = rx_bit + 3'd1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_next = '0;
                    if (rx_line) begin
                        rx_data_next  = rx_shift;
                        rx_ready_next = 1'b1;
                        rx_state_next = RX_IDLE;
                    end else begin
                        rx_error_next = 1'b1;
                        rx_state_next = RX_WAIT_HIGH;
                    end
                end else begin
                    rx_cnt_next = rx_cnt + CNT_ONE;
                end
            end
            RX_WAIT_HIGH: begin
                // A held-low break reports once; wait for the line to recover.
                if (rx_line) begin
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cameralink_uart_core.sv
// Scoreboard bench for cameralink_uart_core: stimulus queues expected frames,
// drops and received bytes; independent monitors compare each cycle.
module tb_cameralink_uart_core;

    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       s_axi_areset;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_drop;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_frame_error;
    logic       uart_tx;
    logic       uart_rx;
    logic       rx_drive;
    logic       loop_en;
    logic       mon_en;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int unsigned start_edge;
        logic [7:0]  data;
    } tx_frame_t;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } rx_evt_t;

    tx_frame_t   tx_q[$];
    int unsigned drop_q[$];
    rx_evt_t     rx_q[$];
    int unsigned free_edge = 0;
    logic [7:0]  last_rx = 8'h00;

    cameralink_uart_core #(.CLKS_PER_BIT(CPB)) dut (
        .s_axi_aclk     (clk),
        .s_axi_areset   (s_axi_areset),
        .tx_start       (tx_start),
        .tx_data        (tx_data),
        .tx_busy        (tx_busy),
        .tx_drop        (tx_drop),
        .rx_ready       (rx_ready),
        .rx_data        (rx_data),
        .rx_frame_error (rx_frame_error),
        .uart_tx        (uart_tx),
        .uart_rx        (uart_rx)
    );

    assign uart_rx = loop_en ? uart_tx : rx_drive;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected line level t cycles into a frame: start, 8 data bits LSB first, stop.
    function automatic logic frame_level(input int unsigned t, input logic [7:0] d);
        int unsigned slot;
        slot = t / CPB;
        if (slot == 0) return 1'b0;
        if (slot >= 9) return 1'b1;
        return d[slot-1];
    endfunction

    // TX monitor: line level, busy and drop pulses every cycle.
    logic exp_tx, exp_busy, exp_drop;
    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            while (tx_q.size() > 0 && cyc >= tx_q[0].start_edge + FRAME) void'(tx_q.pop_front());
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
            if (tx_q.size() > 0 && cyc >= tx_q[0].start_edge) begin
                exp_busy = 1'b1;
                exp_tx   = frame_level(cyc - tx_q[0].start_edge, tx_q[0].data);
            end
            check("uart_tx", {31'd0, uart_tx}, {31'd0, exp_tx});
            check("tx_busy", {31'd0, tx_busy}, {31'd0, exp_busy});
            exp_drop = (drop_q.size() > 0 && drop_q[0] == cyc);
            if (exp_drop) void'(drop_q.pop_front());
            check("tx_drop", {31'd0, tx_drop}, {31'd0, exp_drop});
        end
    end

    // RX monitor: pops one expected event per ready/error pulse; otherwise
    // rx_data must hold the last good byte.
    rx_evt_t ev;
    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (rx_ready || rx_frame_error) begin
                if (rx_q.size() == 0) begin
                    check("rx_unexpected_event", {30'd0, rx_ready, rx_frame_error}, 32'd0);
                end else begin
                    ev = rx_q.pop_front();
                    check("rx_frame_error", {31'd0, rx_frame_error}, {31'd0, ev.is_err});
                    check("rx_ready", {31'd0, rx_ready}, {31'd0, !ev.is_err});
                    if (!ev.is_err) last_rx = ev.data;
                    check("rx_data", {24'd0, rx_data}, {24'd0, last_rx});
                end
            end else begin
                check("rx_data_hold", {24'd0, rx_data}, {24'd0, last_rx});
            end
        end
    end

    // Called at a negedge; returns at the following negedge with tx_start low.
    task automatic tx_send(input logic [7:0] d);
        tx_frame_t f;
        rx_evt_t   e;
        tx_start = 1'b1;
        tx_data  = d;
        if (cyc + 1 >= free_edge) begin
            f.start_edge = cyc + 1;
            f.data       = d;
            tx_q.push_back(f);
            free_edge = cyc + 1 + FRAME + 1;
            if (loop_en) begin
                e.is_err = 1'b0;
                e.data   = d;
                rx_q.push_back(e);
            end
        end else begin
            drop_q.push_back(cyc + 1);
        end
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic tx_send_when_free(input logic [7:0] d);
        while (cyc + 1 < free_edge) @(negedge clk);
        tx_send(d);
    endtask

    task automatic rx_send(input logic [7:0] d, input logic stop, input int hold_low);
        rx_evt_t e;
        e.is_err = !stop;
        e.data   = d;
        rx_q.push_back(e);
        rx_drive = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drive = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx_drive = stop;
        repeat (CPB + hold_low) @(negedge clk);
        rx_drive = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n;
        n = 0;
        while ((rx_q.size() + tx_q.size() + drop_q.size()) != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cycles) check("drain_timeout", rx_q.size() + tx_q.size() + drop_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_uart_tx"}, {31'd0, uart_tx}, 32'd1);
        check({tag, "_tx_busy"}, {31'd0, tx_busy}, 32'd0);
        check({tag, "_tx_drop"}, {31'd0, tx_drop}, 32'd0);
        check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        check({tag, "_rx_data"}, {24'd0, rx_data}, 32'd0);
        check({tag, "_rx_frame_error"}, {31'd0, rx_frame_error}, 32'd0);
    endtask

    initial begin
        int unsigned e0;
        s_axi_areset = 1'b1;
        tx_start     = 1'b0;
        tx_data      = 8'h00;
        rx_drive     = 1'b1;
        loop_en      = 1'b0;
        mon_en       = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        s_axi_areset = 1'b0;
        mon_en       = 1'b1;
        repeat (2) @(negedge clk);

        // 0xA5 waveform, then 0x3C forty cycles in is dropped.
        loop_en = 1'b1;
        tx_send_when_free(8'hA5);
        e0 = free_edge - FRAME - 1;
        while (cyc + 1 < e0 + 40) @(negedge clk);
        tx_send(8'h3C);
        wait_drain(1000);

        // Back-to-back loopback frames.
        tx_send_when_free(8'h5A);
        tx_send_when_free(8'hC3);
        wait_drain(1000);

        // Random loopback traffic with random gaps, including drops.
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                tx_send_when_free(8'($urandom));
            end else begin
                repeat ($urandom_range(0, 200)) @(negedge clk);
                tx_send(8'($urandom));
            end
        end
        wait_drain(2000);

        // Start-bit glitch, good 0x11, then a break with bad stop bit.
        loop_en = 1'b0;
        rx_drive = 1'b0;
        repeat (4) @(negedge clk);
        rx_drive = 1'b1;
        repeat (40) @(negedge clk);
        rx_send(8'h11, 1'b1, 0);
        rx_send(8'hFF, 1'b0, 100);
        wait_drain(1000);

        // Independent TX and RX traffic at the same time.
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    repeat ($urandom_range(0, 120)) @(negedge clk);
                    tx_send(8'($urandom));
                end
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    repeat ($urandom_range(0, 30)) @(negedge clk);
                    if ($urandom_range(0, 3) == 0) rx_send(8'($urandom), 1'b0, $urandom_range(0, 40));
                    else rx_send(8'($urandom), 1'b1, 0);
                end
            end
        join
        wait_drain(2000);

        // Reset in data bit 3 of a 0xF0 frame, then 0x81 sent normally.
        loop_en = 1'b1;
        tx_send_when_free(8'hF0);
        e0 = free_edge - FRAME - 1;
        while (cyc < e0 + CPB + 3 * CPB + 5) @(negedge clk);
        mon_en = 1'b0;
        s_axi_areset = 1'b1;
        #1;
        check("midreset_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("midreset_tx_busy", {31'd0, tx_busy}, 32'd0);
        tx_q.delete();
        drop_q.delete();
        rx_q.delete();
        last_rx   = 8'h00;
        free_edge = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset");
        s_axi_areset = 1'b0;
        mon_en = 1'b1;
        tx_send(8'h81);
        wait_drain(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
